// File: rtl/imem_boot_pkg.sv
// imem_boot_pkg: shared state encoding and constants for the instruction-memory boot loader
// No ports; imported by the loader top and its byte/word assembler.
package imem_boot_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_BYTES,
        S_WRITE,
        S_RUN,
        S_HALTED,
        S_ERROR
    } state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam logic [5:0] HALT_OPCODE = 6'b111001;
endpackage

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: program stream, core control and instruction-memory port bundle
// Ports: none; master = loader side, slave = stream source / core / memory side.
interface imem_boot_loader_if #(parameter int ADDR_W = 5);
    logic              load_start;
    logic              load_valid;
    logic [7:0]        load_data;
    logic              load_ready;
    logic [ADDR_W-1:0] cpu_pc;
    logic              cpu_halt;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic              cpu_reset;
    logic              cpu_run;
    logic              busy;
    logic              error;
    logic [ADDR_W:0]   words_loaded;
    modport master (
        input  load_start, load_valid, load_data, cpu_pc, cpu_halt,
        output load_ready, mem_addr, mem_we, mem_wdata, cpu_reset, cpu_run, busy, error, words_loaded
    );
    modport slave (
        output load_start, load_valid, load_data, cpu_pc, cpu_halt,
        input  load_ready, mem_addr, mem_we, mem_wdata, cpu_reset, cpu_run, busy, error, words_loaded
    );
endinterface

// File: rtl/imem_boot_loader_assembler.sv
// byte_word_assembler: packs a big-endian byte stream into 32-bit words
// Ports: clock_i/reset_i, clear_i (restart byte count), byte_valid_i/byte_i (accepted byte),
//        word_o (last completed word), word_done_o (this byte completes a word).
module byte_word_assembler
    import imem_boot_pkg::*;
(
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_done_o
);
    logic [23:0] sh_q;
    logic [1:0]  cnt_q;
    logic [31:0] word_q;
    assign word_done_o = byte_valid_i && cnt_q == 2'(BYTES_PER_WORD - 1);
    assign word_o = word_q;
    // The completed word is held separately so it stays stable while the next word streams in.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            word_q <= '0;
        end else if (clear_i) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else if (byte_valid_i) begin
            sh_q  <= {sh_q[15:0], byte_i};
            cnt_q <= cnt_q + 2'd1;
            if (word_done_o) word_q <= {sh_q, byte_i};
        end
    end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a program into instruction RAM, then releases the core and arbitrates the memory port
// Ports: clock_i, reset_i (async active-high), bus (imem_boot_loader_if.master: load stream,
//        core pc/halt in, memory write port and core reset/run/status out).
module imem_boot_loader
    import imem_boot_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic clock_i,
    input  logic reset_i,
    imem_boot_loader_if.master bus
);
    localparam int CW = ADDR_W + 1;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, n_q, n_d;
    logic          start, accept, word_done, core_owns;
    logic [31:0]   word;
    assign start = bus.load_start && (state_q == S_IDLE || state_q == S_HALTED || state_q == S_ERROR);
    assign bus.load_ready = state_q == S_COUNT || state_q == S_BYTES;
    assign accept = bus.load_valid && bus.load_ready;
    assign core_owns = state_q == S_RUN || state_q == S_HALTED;
    byte_word_assembler u_asm (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .clear_i     (start),
        .byte_valid_i(accept && state_q == S_BYTES),
        .byte_i      (bus.load_data),
        .word_o      (word),
        .word_done_o (word_done)
    );
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        if (start) begin
            state_d = S_COUNT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_COUNT: if (accept) begin
                    state_d = (bus.load_data == 8'd0 || bus.load_data > 8'(DEPTH)) ? S_ERROR : S_BYTES;
                    n_d     = CW'(bus.load_data);
                end
                S_BYTES: state_d = word_done ? S_WRITE : S_BYTES;
                S_WRITE: begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = (cnt_d == n_q) ? S_RUN : S_BYTES;
                end
                S_RUN:   state_d = bus.cpu_halt ? S_HALTED : S_RUN;
                default: state_d = state_q;
            endcase
        end
    end
    // The word counter doubles as the write address and the words_loaded count.
    assign bus.mem_addr     = core_owns ? bus.cpu_pc : cnt_q[ADDR_W-1:0];
    assign bus.mem_we       = state_q == S_WRITE;
    assign bus.mem_wdata    = word;
    assign bus.cpu_reset    = !core_owns;
    assign bus.cpu_run      = state_q == S_RUN;
    assign bus.busy         = state_q == S_COUNT || state_q == S_BYTES || state_q == S_WRITE;
    assign bus.error        = state_q == S_ERROR;
    assign bus.words_loaded = cnt_q;
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;
    logic clock_i = 1'b0;
    logic reset_i = 1'b1;
    int   checks = 0;
    int   errors = 0;
    imem_boot_loader_if #(.ADDR_W(5)) bus ();
    imem_boot_loader #(.ADDR_W(5), .DEPTH(32)) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .bus    (bus)
    );
    always #5 clock_i = ~clock_i;
    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic start_pulse();
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        chk("start_busy", 32'(bus.busy), 1);
        chk("start_ready", 32'(bus.load_ready), 1);
        chk("start_error", 32'(bus.error), 0);
        chk("start_words", 32'(bus.words_loaded), 0);
        chk("start_cpu_reset", 32'(bus.cpu_reset), 1);
        chk("start_cpu_run", 32'(bus.cpu_run), 0);
    endtask
    task automatic send(input logic [7:0] b, input int gap);
        for (int i = 0; i < gap; i++) begin
            bus.load_valid = 1'b0;
            chk("gap_ready", 32'(bus.load_ready), 1);
            chk("gap_we", 32'(bus.mem_we), 0);
            tick();
        end
        bus.load_valid = 1'b1;
        bus.load_data  = b;
        chk("send_ready", 32'(bus.load_ready), 1);
        tick();
        bus.load_valid = 1'b0;
    endtask
    task automatic send_word(input logic [31:0] w, input int idx, input int gap);
        send(w[31:24], gap);
        send(w[23:16], gap);
        send(w[15:8], gap);
        send(w[7:0], gap);
        chk("wr_we", 32'(bus.mem_we), 1);
        chk("wr_addr", 32'(bus.mem_addr), 32'(idx));
        chk("wr_data", bus.mem_wdata, w);
        chk("wr_ready", 32'(bus.load_ready), 0);
        tick();
        chk("post_wr_we", 32'(bus.mem_we), 0);
        chk("post_wr_words", 32'(bus.words_loaded), 32'(idx + 1));
    endtask
    task automatic check_run(input logic [31:0] last, input int n);
        chk("run_cpu_run", 32'(bus.cpu_run), 1);
        chk("run_cpu_reset", 32'(bus.cpu_reset), 0);
        chk("run_busy", 32'(bus.busy), 0);
        chk("run_words", 32'(bus.words_loaded), 32'(n));
        chk("run_wdata_hold", bus.mem_wdata, last);
    endtask
    task automatic load_prog(input int gap);
        start_pulse();
        send(8'h02, gap);
        send_word(32'h60010006, 0, gap);
        send_word(32'h3C030000, 1, gap);
        check_run(32'h3C030000, 2);
    endtask
    task automatic halt();
        bus.cpu_halt = 1'b1;
        tick();
        bus.cpu_halt = 1'b0;
        chk("halt_cpu_run", 32'(bus.cpu_run), 0);
        chk("halt_cpu_reset", 32'(bus.cpu_reset), 0);
    endtask
    task automatic count_error(input logic [7:0] n);
        start_pulse();
        send(n, 0);
        chk("err_flag", 32'(bus.error), 1);
        chk("err_cpu_reset", 32'(bus.cpu_reset), 1);
        chk("err_ready", 32'(bus.load_ready), 0);
        chk("err_busy", 32'(bus.busy), 0);
        bus.load_valid = 1'b1;
        bus.load_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            chk("err_we", 32'(bus.mem_we), 0);
            tick();
        end
        bus.load_valid = 1'b0;
        chk("err_sticky", 32'(bus.error), 1);
    endtask
    initial begin
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        bus.cpu_pc     = '0;
        bus.cpu_halt   = 1'b0;
        #23;
        chk("rst_cpu_reset", 32'(bus.cpu_reset), 1);
        chk("rst_cpu_run", 32'(bus.cpu_run), 0);
        chk("rst_ready", 32'(bus.load_ready), 0);
        chk("rst_we", 32'(bus.mem_we), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_error", 32'(bus.error), 0);
        chk("rst_words", 32'(bus.words_loaded), 0);
        chk("rst_addr", 32'(bus.mem_addr), 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        tick();
        reset_i = 1'b0;
        tick();
        load_prog(0);
        bus.cpu_pc = 5'd7;
        #1;
        chk("run_pc_addr", 32'(bus.mem_addr), 7);
        bus.cpu_halt = 1'b0;
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        chk("run_start_ignored", 32'(bus.cpu_run), 1);
        chk("run_start_busy", 32'(bus.busy), 0);
        halt();
        chk("halt_pc_addr", 32'(bus.mem_addr), 7);
        tick();
        chk("halted_stays", 32'(bus.cpu_run), 0);
        load_prog(3);
        halt();
        count_error(8'h00);
        count_error(8'h21);
        start_pulse();
        send(8'h01, 0);
        send_word(32'hDEADBEEF, 0, 0);
        check_run(32'hDEADBEEF, 1);
        halt();
        start_pulse();
        send(8'h02, 0);
        send(8'h11, 0);
        send(8'h22, 0);
        #2;
        reset_i = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(bus.load_ready), 0);
        chk("mid_rst_cpu_reset", 32'(bus.cpu_reset), 1);
        chk("mid_rst_words", 32'(bus.words_loaded), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        tick();
        reset_i = 1'b0;
        tick();
        load_prog(0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Boot controller and port arbiter for the single-cycle core's instruction memory.
- After a start pulse, receives a program over a byte-wide valid/ready stream, assembles 32-bit words and writes them into instruction RAM.
- Then releases the core (reset off, run on) and hands the memory address port to the core's PC.
- Returns to a halted state when the core executes halt, and can be reloaded without a global reset.

Parameters:
ADDR_W, 5, instruction memory address width in words
DEPTH, 32, number of instruction words; must satisfy DEPTH <= 2**ADDR_W and DEPTH <= 255

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
load_start  in  1  one-cycle pulse requesting a new program load
load_valid  in  1  byte available on load_data
load_data  in  8  program byte stream
load_ready  out  1  loader accepts a byte this cycle
cpu_pc  in  ADDR_W  core program counter (word index)
cpu_halt  in  1  core decoded the halt opcode this cycle
mem_addr  out  ADDR_W  instruction memory address (arbitrated)
mem_we  out  1  instruction memory write strobe, one cycle per word
mem_wdata  out  32  word to write
cpu_reset  out  1  holds core in reset while not running
cpu_run  out  1  core may fetch and execute
busy  out  1  load in progress (COUNT, BYTES or WRITE)
error  out  1  last load rejected; sticky until next accepted load_start
words_loaded  out  ADDR_W+1  words written by the current or last load

Behaviour:
- Reset (async):
  - state IDLE; cpu_reset=1; all other outputs 0; word index 0; byte counter 0.
- States: IDLE, COUNT, BYTES, WRITE, RUN, HALTED, ERROR.
- load_start:
  - Honoured only in IDLE, HALTED and ERROR; ignored in every other state.
  - Next cycle: state COUNT, error=0, words_loaded=0, cpu_run=0, cpu_reset=1.
- COUNT:
  - load_ready=1. The first accepted byte (valid&&ready) is the word count N.
  - N==0 or N>DEPTH: go to ERROR.
  - Otherwise latch N and go to BYTES.
- BYTES:
  - load_ready=1. Bytes are accepted big-endian, first byte -> bits 31:24.
  - Gaps in load_valid are permitted; no timeout.
  - On the 4th accepted byte, go to WRITE.
- WRITE (exactly one cycle):
  - load_ready=0, mem_we=1, mem_addr=word index, mem_wdata=assembled word.
  - Next cycle: word index+1, words_loaded+1, byte counter 0.
  - If the word just written was index N-1, go to RUN; otherwise go to BYTES.
- RUN:
  - cpu_reset=0, cpu_run=1 from the first RUN cycle.
  - mem_addr = cpu_pc combinationally, mem_we=0.
  - cpu_halt=1: next cycle state HALTED.
- HALTED: cpu_run=0, cpu_reset=0 (core registers remain inspectable), mem_addr = cpu_pc.
- ERROR: error=1, cpu_reset=1, load_ready=0.
- mem_addr outside RUN and HALTED is the current word index. mem_wdata holds the last assembled word when mem_we=0.
- cpu_halt is ignored outside RUN.
- load_valid outside COUNT and BYTES is not consumed (load_ready=0).
- Reset mid-load: all state lost. Memory contents are undefined to the core until a complete reload.
- A byte is never accepted in the same cycle as the write strobe.

Decomposition:
- Shared package imem_boot_pkg holds:
  - state encoding;
  - BYTES_PER_WORD=4;
  - HALT_OPCODE=6'b111001 (used by the core decode that drives cpu_halt).
- One natural sub-module, byte_word_assembler: 32-bit shift register plus 2-bit byte counter, with a word_done output and a clear input.

Test Plan:
- Two-word load: start pulse, then bytes 0x02, 0x60,0x01,0x00,0x06, 0x3C,0x03,0x00,0x00. Required:
  - mem_we pulses twice: addr 0 / data 0x60010006, then addr 1 / data 0x3C030000;
  - words_loaded=2;
  - cpu_run=1 and cpu_reset=0 on the cycle after the second write.
- Stalled stream: same program with load_valid low for 3 cycles between every byte -> identical writes and data, load_ready stays 1 during gaps.
- Count errors:
  - count byte 0x00 -> ERROR, error=1, no mem_we, cpu_reset=1;
  - count byte 0x21 with DEPTH=32 -> same response;
  - a following start pulse clears error and loads normally.
- Halt and reload:
  - In RUN, drive cpu_pc=7 -> mem_addr=7.
  - Pulse cpu_halt -> HALTED next cycle, cpu_run=0.
  - load_start in HALTED -> COUNT, cpu_reset=1.
  - load_start during RUN -> ignored, state stays RUN.
- Reset mid-load: assert reset after 2 of 4 bytes of word 0 -> immediately IDLE, load_ready=0, cpu_reset=1, words_loaded=0; a fresh load then writes word 0 from its first byte.
